wtb_load_scheduler: RTL and testbench
=====================================

Name: wtb_load_scheduler

Overview:
- Arbitrates wavetable-load requests from NUM_VOICES voice channels onto the single shared wavetable_loader.
- Sequences each load: grant, one-cycle load strobe, wait for completion, per-voice acknowledge.
- Round-robin fairness; one load in flight at a time.
- Sits between per-voice program-change logic and the wavetable_loader/wavetable_ram write side.

Parameters:
- NUM_VOICES, 4, number of requesting voices (2..8)
- VOICE_W, 2, width of voice index; must equal clog2(NUM_VOICES)
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_VOICES  level load request per voice; held until that voice's ack
- req_wtb_num  in  5*NUM_VOICES  requested wavetable number; voice i uses bits [5i+4:5i]
- ack  out  NUM_VOICES  one-cycle pulse per voice on load completion
- busy  out  1  high from grant until ack (inclusive)
- num_err  out  1  sticky flag: loader done number differed from issued number
- ldr_load  out  1  one-cycle load strobe to the loader
- ldr_wtb_num  out  5  wavetable number to the loader; stable from ISSUE through DONE
- ldr_voice_num  out  VOICE_W  granted voice index to the loader
- ldr_done  in  1  loader completion pulse
- ldr_done_num  in  5  wavetable number reported by the loader with ldr_done
- ldr_idle  in  1  loader idle status

Behaviour:
- Reset values: state IDLE; ack 0; busy 0; num_err 0; ldr_load 0; ldr_wtb_num 0; ldr_voice_num 0; round-robin pointer rr_ptr 0.
- All outputs are registered. The FSM has four states.
- IDLE:
  - If any req bit is set and ldr_idle=1, pick the first set bit at or after rr_ptr, wrapping modulo NUM_VOICES.
  - Latch the chosen index into ldr_voice_num and that voice's 5-bit field into ldr_wtb_num.
  - Set busy=1 and go to ISSUE.
  - If ldr_idle=0, stay in IDLE; no grant is made.
- ISSUE: ldr_load=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - Stay until ldr_done=1.
  - On ldr_done, if ldr_done_num != ldr_wtb_num, set num_err=1. num_err clears only on rst.
  - Go to DONE.
  - A ldr_done arriving in the same cycle as entry to WAIT is accepted.
- DONE:
  - Pulse ack[ldr_voice_num] for one cycle.
  - Set rr_ptr = (ldr_voice_num+1) mod NUM_VOICES.
  - busy=0 on the next cycle; go to IDLE.
- Latency: req rises in cycle N with loader idle → ldr_load in N+2; ack in the cycle after ldr_done is seen + 1. Minimum req-to-ack is 4 cycles.
- Back-to-back grants: IDLE may grant in the cycle after DONE, so the minimum gap between ldr_load strobes is 4 cycles.
- A requesting voice must deassert req in the cycle after its ack, or it is re-eligible. Because rr_ptr has advanced, other pending voices are served first.
- Request withdrawn during ISSUE/WAIT: the load still completes and ack still pulses. The requester ignores the ack.
- req_wtb_num changes after grant have no effect on the in-flight load.
- Simultaneous requests: strict round-robin from rr_ptr. With all voices requesting continuously, the grant order is 0,1,2,3,0,… and no voice waits more than NUM_VOICES-1 loads.
- ldr_done in IDLE or ISSUE is ignored.
- rst mid-operation: all state returns to reset values immediately. The loader is not aborted; its later ldr_done is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: WTB_LOAD_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without ldr_done, the FSM goes to DONE, pulses ack for the granted voice, and sets sticky output timeout_err (extra port, 1 bit, reset 0).
  - The counter clears on entry to WAIT.
- When undefined: there is no counter and no timeout_err port; WAIT can last forever.

Test Plan:
- Single request: req=4'b0100, req_wtb_num[14:10]=5'd17, ldr_idle=1, ldr_done 10 cycles after ldr_load with done_num 17. Expect ldr_load one cycle, ldr_voice_num=2, ldr_wtb_num=17, a single ack[2] pulse, and num_err=0.
- All four voices request continuously, with the loader completing in 3 cycles. Expect grant order 0,1,2,3,0 and exactly one ack pulse per grant.
- Loader busy: ldr_idle=0 for 20 cycles with req=4'b0001. Expect no ldr_load until ldr_idle=1, then ldr_load 2 cycles later.
- Mismatch: issue wtb_num 5, return ldr_done_num 6. Expect num_err=1, ack still pulses, and num_err remains set until rst.
- Reset mid-WAIT: assert rst while busy=1, then send ldr_done. Expect all outputs 0 and no ack. rr_ptr=0, so with all four voices requesting, the next grant goes to voice 0.
- With WTB_LOAD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, never send ldr_done. Expect ack for the granted voice 16–17 cycles after entering WAIT and timeout_err=1.

Source files
------------

// File: rtl/wtb_load_scheduler.sv
// ----------------------------------------------------------------------------
// wtb_load_scheduler
//
// Purpose:
//   Arbitrates wavetable-load requests from NUM_VOICES voice channels onto the
//   single shared wavetable loader. Only one load is in flight at a time.
//   Each load is sequenced as: grant (IDLE) -> one-cycle load strobe (ISSUE)
//   -> wait for loader completion (WAIT) -> per-voice acknowledge (DONE).
//   Voices are served round-robin, starting after the most recently served one.
//
// Optional feature (compile-time macro WTB_LOAD_SCHED_TIMEOUT_EN):
//   Adds a watchdog counter in WAIT. If the loader does not report completion
//   within TIMEOUT_CYCLES cycles, the load is finished anyway: the voice is
//   acknowledged and the sticky timeout_err output is set. Without the macro
//   there is no counter and no timeout_err port.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   req            in   [NUM_VOICES]   level request per voice, held until ack
//   req_wtb_num    in   [5*NUM_VOICES] wavetable number, voice i at [5i+4:5i]
//   ack            out  [NUM_VOICES]   one-cycle completion pulse per voice
//   busy           out  high from grant until ack (inclusive)
//   num_err        out  sticky: loader reported a different wavetable number
//   ldr_load       out  one-cycle load strobe to the loader
//   ldr_wtb_num    out  [5]       wavetable number for the loader
//   ldr_voice_num  out  [VOICE_W] granted voice index
//   ldr_done       in   loader completion pulse
//   ldr_done_num   in   [5]       wavetable number reported with ldr_done
//   ldr_idle       in   loader idle status; no grant is made while low
//   timeout_err    out  sticky watchdog flag (only with the macro defined)
// ----------------------------------------------------------------------------
module wtb_load_scheduler #(
  parameter int NUM_VOICES     = 4,
  parameter int VOICE_W        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VOICES-1:0]   req,
  input  logic [5*NUM_VOICES-1:0] req_wtb_num,
  output logic [NUM_VOICES-1:0]   ack,
  output logic                    busy,
  output logic                    num_err,
  output logic                    ldr_load,
  output logic [4:0]              ldr_wtb_num,
  output logic [VOICE_W-1:0]      ldr_voice_num,
  input  logic                    ldr_done,
  input  logic [4:0]              ldr_done_num,
  input  logic                    ldr_idle
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  // Elaboration-time sanity check of the parameter set.
  if ((VOICE_W != $clog2(NUM_VOICES)) || (NUM_VOICES < 2) || (NUM_VOICES > 8) ||
      (TIMEOUT_CYCLES < 1)) begin : g_cfg_err
    $error("wtb_load_scheduler: inconsistent NUM_VOICES/VOICE_W/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [NUM_VOICES-1:0]   r_ack;
  logic                    r_busy;
  logic                    r_num_err;
  logic                    r_load;
  logic [4:0]              r_wtb;
  logic [VOICE_W-1:0]      r_voice;
  logic [VOICE_W-1:0]      r_rr_ptr;

`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_to_err;
`endif

  logic [NUM_VOICES-1:0]   w_elig;
  logic [VOICE_W:0]        w_pick;
  logic                    w_pick_vld;
  logic [VOICE_W-1:0]      w_pick_idx;
  logic [5*NUM_VOICES-1:0] w_wtb_shift;
  logic [4:0]              w_pick_wtb;

  // Round-robin search: the first eligible voice at or after ptr, wrapping.
  // Offsets are scanned from the far end so the nearest hit is written last.
  // Returns {valid, index}.
  function automatic logic [VOICE_W:0] rr_pick(input logic [NUM_VOICES-1:0] elig,
                                               input logic [VOICE_W-1:0]    ptr);
    logic [NUM_VOICES-1:0] sh;
    logic [VOICE_W:0]      res;
    int                    idx;
    res = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
      sh = elig >> idx;
      if (sh[0]) res = {1'b1, VOICE_W'(idx)};
    end
    return res;
  endfunction

  // The voice being acknowledged this cycle still holds req (it drops it the
  // following cycle), so it is masked out to avoid an immediate duplicate load.
  assign w_elig      = req & ~r_ack;
  assign w_pick      = rr_pick(w_elig, r_rr_ptr);
  assign w_pick_vld  = w_pick[VOICE_W];
  assign w_pick_idx  = w_pick[VOICE_W-1:0];
  assign w_wtb_shift = req_wtb_num >> (5 * int'(w_pick_idx));
  assign w_pick_wtb  = w_wtb_shift[4:0];

  // Sequencer. Outputs are registered, so the strobe decided in ISSUE is
  // visible during the first WAIT cycle; a ldr_done in that same cycle is
  // therefore legal and accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ack     <= '0;
      r_busy    <= 1'b0;
      r_num_err <= 1'b0;
      r_load    <= 1'b0;
      r_wtb     <= '0;
      r_voice   <= '0;
      r_rr_ptr  <= '0;
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_to_err  <= 1'b0;
`endif
    end else begin
      r_ack  <= '0;
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld && ldr_idle) begin
            r_voice <= w_pick_idx;
            r_wtb   <= w_pick_wtb;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_load   <= 1'b1;
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
          r_to_cnt <= '0;
`endif
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (ldr_done) begin
            if (ldr_done_num != r_wtb) r_num_err <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_to_err <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_ack <= NUM_VOICES'(1) << r_voice;
          if (r_voice == VOICE_W'(NUM_VOICES - 1)) r_rr_ptr <= '0;
          else                                     r_rr_ptr <= r_voice + 1'b1;
          // busy stays high through the ack cycle; IDLE clears it afterwards
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack           = r_ack;
  assign busy          = r_busy;
  assign num_err       = r_num_err;
  assign ldr_load      = r_load;
  assign ldr_wtb_num   = r_wtb;
  assign ldr_voice_num = r_voice;
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
  assign timeout_err   = r_to_err;
`endif

endmodule

// File: tb/tb_wtb_load_scheduler.sv
// ----------------------------------------------------------------------------
// tb_wtb_load_scheduler
//
// Directed bench for wtb_load_scheduler (NUM_VOICES=4). Expected grants and
// acks are queued when stimulus is issued; a negedge monitor pops and compares
// them whenever the DUT strobes ldr_load or pulses ack. A small loader model
// answers each load after done_dly cycles with number + done_off.
// ----------------------------------------------------------------------------
module tb_wtb_load_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] req_wtb_num;
  logic [3:0]  ack;
  logic        busy;
  logic        num_err;
  logic        ldr_load;
  logic [4:0]  ldr_wtb_num;
  logic [1:0]  ldr_voice_num;
  logic        ldr_done;
  logic [4:0]  ldr_done_num;
  logic        ldr_idle;
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
  logic        timeout_err;
`endif

  wtb_load_scheduler #(
    .NUM_VOICES    (4),
    .VOICE_W       (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_wtb_num  (req_wtb_num),
    .ack          (ack),
    .busy         (busy),
    .num_err      (num_err),
    .ldr_load     (ldr_load),
    .ldr_wtb_num  (ldr_wtb_num),
    .ldr_voice_num(ldr_voice_num),
    .ldr_done     (ldr_done),
    .ldr_done_num (ldr_done_num),
    .ldr_idle     (ldr_idle)
`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  typedef struct {
    int voice;
    int wtb;
  } grant_t;

  grant_t     exp_grant[$];
  logic [3:0] exp_ack[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_loads = 0;
  int n_acks = 0;
  int last_load_cyc = 0;
  int last_ack_cyc = 0;
  int done_cyc = 0;
  int req_cyc = 0;
  int done_dly = 3;
  int done_off = 0;
  bit resp_en = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wtb(input int v, input int n);
    req_wtb_num[5*v +: 5] = 5'(n);
  endtask

  task automatic wait_loads(input int target, input int limit, input string name);
    for (int i = 0; i < limit && n_loads < target; i++) @(posedge clk);
    #1;
    chk(name, n_loads, target);
  endtask

  task automatic wait_acks(input int target, input int limit, input string name);
    for (int i = 0; i < limit && n_acks < target; i++) @(posedge clk);
    #1;
    chk(name, n_acks, target);
  endtask

  // Monitor: compare each load strobe and each ack pulse against the queues.
  initial begin
    grant_t     g;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ldr_load) begin
          n_loads++;
          last_load_cyc = cyc;
          if (exp_grant.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_load: voice %0d wtb %0d, required no load",
                     ldr_voice_num, ldr_wtb_num);
          end else begin
            g = exp_grant.pop_front();
            chk("grant_voice", int'(ldr_voice_num), g.voice);
            chk("grant_wtb", int'(ldr_wtb_num), g.wtb);
          end
        end
        if (ack != 4'b0000) begin
          n_acks++;
          last_ack_cyc = cyc;
          chk("busy_during_ack", int'(busy), 1);
          if (exp_ack.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: ack %b, required none", ack);
          end else begin
            a = exp_ack.pop_front();
            chk("ack_vector", int'(ack), int'(a));
          end
        end
      end
    end
  end

  // Loader model: completes each load done_dly cycles after the strobe.
  initial begin
    logic [4:0] num;
    ldr_done     = 1'b0;
    ldr_done_num = 5'd0;
    forever begin
      @(negedge clk);
      if (ldr_load && resp_en && !rst) begin
        num = ldr_wtb_num;
        repeat (done_dly) @(posedge clk);
        #1;
        ldr_done     = 1'b1;
        ldr_done_num = num + 5'(done_off);
        done_cyc     = cyc;
        @(posedge clk);
        #1;
        ldr_done     = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req         = 4'b0000;
    req_wtb_num = 20'd0;
    ldr_idle    = 1'b1;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_num_err", int'(num_err), 0);
    chk("rst_ldr_load", int'(ldr_load), 0);
    chk("rst_ldr_wtb_num", int'(ldr_wtb_num), 0);
    chk("rst_ldr_voice_num", int'(ldr_voice_num), 0);
    step(1);
    rst = 1'b0;
    step(2);

    // Single request: voice 2, wavetable 17, done 10 cycles after load
    set_wtb(2, 17);
    exp_grant.push_back('{2, 17});
    exp_ack.push_back(4'b0100);
    done_dly = 10;
    req      = 4'b0100;
    req_cyc  = cyc;
    wait_loads(1, 10, "t1_load_seen");
    chk("t1_load_latency", last_load_cyc - req_cyc, 2);
    @(negedge clk);
    chk("t1_busy_in_wait", int'(busy), 1);
    wait_acks(1, 30, "t1_ack_seen");
    req = 4'b0000;
    chk("t1_ack_latency", last_ack_cyc - done_cyc, 2);
    @(negedge clk);
    chk("t1_busy_after_ack", int'(busy), 0);
    chk("t1_num_err", int'(num_err), 0);

    // Loader busy: no grant while ldr_idle is low
    step(2);
    ldr_idle = 1'b0;
    set_wtb(0, 9);
    req = 4'b0001;
    step(20);
    chk("t3_no_load_while_busy", n_loads, 1);
    exp_grant.push_back('{0, 9});
    exp_ack.push_back(4'b0001);
    done_dly = 3;
    ldr_idle = 1'b1;
    req_cyc  = cyc;
    wait_loads(2, 10, "t3_load_seen");
    chk("t3_load_latency", last_load_cyc - req_cyc, 2);
    wait_acks(2, 30, "t3_ack_seen");
    req = 4'b0000;

    // Number mismatch: issue 5, loader reports 6
    step(2);
    set_wtb(1, 5);
    done_off = 1;
    exp_grant.push_back('{1, 5});
    exp_ack.push_back(4'b0010);
    req = 4'b0010;
    wait_acks(3, 40, "t4_ack_seen");
    req      = 4'b0000;
    done_off = 0;
    @(negedge clk);
    chk("t4_num_err_set", int'(num_err), 1);
    step(5);
    @(negedge clk);
    chk("t4_num_err_sticky", int'(num_err), 1);

    // Reset while waiting for the loader; the late ldr_done must be ignored
    step(1);
    set_wtb(1, 12);
    done_dly = 8;
    exp_grant.push_back('{1, 12});
    req = 4'b0010;
    wait_loads(4, 10, "t5_load_seen");
    step(3);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ack", int'(ack), 0);
    chk("t5_rst_ldr_load", int'(ldr_load), 0);
    chk("t5_rst_num_err", int'(num_err), 0);
    chk("t5_rst_ldr_wtb_num", int'(ldr_wtb_num), 0);
    chk("t5_rst_ldr_voice_num", int'(ldr_voice_num), 0);
    step(2);
    rst = 1'b0;
    step(12);
    chk("t5_no_ack_after_rst", n_acks, 3);

    // All voices requesting: strict round-robin from voice 0
    set_wtb(0, 3);
    set_wtb(1, 7);
    set_wtb(2, 11);
    set_wtb(3, 30);
    done_dly = 3;
    exp_grant.push_back('{0, 3});
    exp_grant.push_back('{1, 7});
    exp_grant.push_back('{2, 11});
    exp_grant.push_back('{3, 30});
    exp_grant.push_back('{0, 3});
    exp_ack.push_back(4'b0001);
    exp_ack.push_back(4'b0010);
    exp_ack.push_back(4'b0100);
    exp_ack.push_back(4'b1000);
    exp_ack.push_back(4'b0001);
    req = 4'b1111;
    wait_loads(9, 80, "t6_loads_seen");
    // withdrawn mid-load: the fifth load still completes and acks
    req = 4'b0000;
    wait_acks(8, 40, "t6_acks_seen");
    step(3);
    chk("t6_num_err_clear", int'(num_err), 0);
    chk("t6_busy_idle", int'(busy), 0);

`ifdef WTB_LOAD_SCHED_TIMEOUT_EN
    // Watchdog: loader never answers
    chk("t7_timeout_err_before", int'(timeout_err), 0);
    resp_en = 1'b0;
    set_wtb(2, 17);
    exp_grant.push_back('{2, 17});
    exp_ack.push_back(4'b0100);
    req = 4'b0100;
    wait_loads(10, 10, "t7_load_seen");
    wait_acks(9, 40, "t7_ack_seen");
    req = 4'b0000;
    chk("t7_ack_delay_16_17",
        int'((last_ack_cyc - last_load_cyc == 16) || (last_ack_cyc - last_load_cyc == 17)), 1);
    @(negedge clk);
    chk("t7_timeout_err_set", int'(timeout_err), 1);
    resp_en = 1'b1;
`endif

    step(4);
    chk("queue_grants_drained", exp_grant.size(), 0);
    chk("queue_acks_drained", exp_ack.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
